// File: rtl/lsu_stage.sv
// Load/store unit between EX/MEM and MEM/WB: request/grant/response bus, lane steering, precise exceptions.
// Optional bus timeout (exception cause 2) is enabled by defining LSU_TIMEOUT_EN.
module lsu_stage #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_mem_read,
  input  logic              ex_mem_write,
  input  logic [2:0]        ex_funct3,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [31:0]       ex_wdata,
  input  logic [31:0]       ex_alu_result,
  input  logic [4:0]        ex_rd,
  input  logic              ex_reg_write,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic [31:0]       wb_data,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [3:0]        bus_be,
  output logic [31:0]       bus_wdata,
  input  logic              bus_gnt,
  input  logic              bus_rvalid,
  input  logic [31:0]       bus_rdata,
  output logic              exc_valid,
  output logic [1:0]        exc_cause
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_is_load;
  logic [2:0]  r_funct3;
  logic [1:0]  r_lane;
  logic [4:0]  r_rd;
  logic        r_reg_write;

  logic        w_accept, w_is_mem, w_illegal, w_misal, w_exc, w_timeout;
  logic [1:0]  w_cause;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_shift, w_load;

  assign ex_ready = (r_state == S_IDLE);
  assign w_accept = ex_valid && ex_ready;
  assign w_is_mem = ex_mem_read || ex_mem_write;

  always_comb begin
    w_illegal = 1'b0;
    if (ex_mem_read && ex_mem_write) begin
      w_illegal = 1'b1;
    end else if (ex_mem_read) begin
      case (ex_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: w_illegal = 1'b0;
        default:                                w_illegal = 1'b1;
      endcase
    end else if (ex_mem_write) begin
      w_illegal = (ex_funct3 != 3'b000) && (ex_funct3 != 3'b001) && (ex_funct3 != 3'b010);
    end
    w_misal = !w_illegal &&
              (((ex_funct3[1:0] == 2'b01) && ex_addr[0]) ||
               ((ex_funct3[1:0] == 2'b10) && (ex_addr[1:0] != 2'b00)));
    w_exc   = w_is_mem && (w_illegal || w_misal);
    w_cause = w_illegal ? 2'd3 : (ex_mem_read ? 2'd0 : 2'd1);
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = ex_wdata;
    case (ex_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << ex_addr[1:0];
        w_wdata = {4{ex_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << ex_addr[1:0];
        w_wdata = {2{ex_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Byte lanes shift by the full offset; halfword lanes only by offset bit 1.
  always_comb begin
    w_shift = bus_rdata >> {r_lane, 3'b000};
    w_load  = bus_rdata;
    case (r_funct3)
      3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
      3'b100:  w_load = {24'd0, w_shift[7:0]};
      3'b001:  w_load = r_lane[1] ? {{16{bus_rdata[31]}}, bus_rdata[31:16]}
                                  : {{16{bus_rdata[15]}}, bus_rdata[15:0]};
      3'b101:  w_load = r_lane[1] ? {16'd0, bus_rdata[31:16]} : {16'd0, bus_rdata[15:0]};
      default: w_load = bus_rdata;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || r_state == S_IDLE) r_cnt <= '0;
    else                          r_cnt <= r_cnt + 1'b1;
  end

  assign w_timeout = (r_state != S_IDLE) && (r_cnt == TO_LAST);
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // A grant or response in the final timeout cycle completes normally.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept && w_is_mem && !w_exc) w_state_nxt = S_REQ;
      S_REQ: begin
        if (bus_gnt)        w_state_nxt = r_is_load ? S_RESP : S_IDLE;
        else if (w_timeout) w_state_nxt = S_IDLE;
      end
      S_RESP: if (bus_rvalid || w_timeout) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_valid     <= 1'b0;
      wb_rd        <= '0;
      wb_reg_write <= 1'b0;
      wb_data      <= '0;
      exc_valid    <= 1'b0;
      exc_cause    <= '0;
      bus_req      <= 1'b0;
      bus_we       <= 1'b0;
      bus_addr     <= '0;
      bus_be       <= '0;
      bus_wdata    <= '0;
      r_is_load    <= 1'b0;
      r_funct3     <= '0;
      r_lane       <= '0;
      r_rd         <= '0;
      r_reg_write  <= 1'b0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      case (r_state)
        S_IDLE: if (w_accept) begin
          if (!w_is_mem) begin
            wb_valid     <= 1'b1;
            wb_data      <= ex_alu_result;
            wb_rd        <= ex_rd;
            wb_reg_write <= ex_reg_write;
          end else if (w_exc) begin
            wb_valid     <= 1'b1;
            exc_valid    <= 1'b1;
            exc_cause    <= w_cause;
            wb_rd        <= ex_rd;
            wb_reg_write <= 1'b0;
          end else begin
            bus_req     <= 1'b1;
            bus_we      <= ex_mem_write;
            bus_addr    <= {ex_addr[ADDR_W-1:2], 2'b00};
            bus_be      <= w_be;
            bus_wdata   <= w_wdata;
            r_is_load   <= ex_mem_read;
            r_funct3    <= ex_funct3;
            r_lane      <= ex_addr[1:0];
            r_rd        <= ex_rd;
            r_reg_write <= ex_reg_write;
          end
        end
        S_REQ: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
            if (!r_is_load) begin
              wb_valid     <= 1'b1;
              wb_rd        <= r_rd;
              wb_reg_write <= 1'b0;
            end
          end else if (w_timeout) begin
            bus_req      <= 1'b0;
            wb_valid     <= 1'b1;
            exc_valid    <= 1'b1;
            exc_cause    <= 2'd2;
            wb_rd        <= r_rd;
            wb_reg_write <= 1'b0;
          end
        end
        S_RESP: begin
          if (bus_rvalid) begin
            wb_valid     <= 1'b1;
            wb_data      <= w_load;
            wb_rd        <= r_rd;
            wb_reg_write <= r_reg_write;
          end else if (w_timeout) begin
            wb_valid     <= 1'b1;
            exc_valid    <= 1'b1;
            exc_cause    <= 2'd2;
            wb_rd        <= r_rd;
            wb_reg_write <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed bench for lsu_stage: expected writebacks are queued at issue and popped when wb_valid appears.
// The timeout step runs only when LSU_TIMEOUT_EN is defined.
module tb_lsu_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready, ex_mem_read, ex_mem_write, ex_reg_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata, ex_alu_result;
  logic [4:0]  ex_rd;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        bus_req, bus_we, bus_gnt, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;
  logic        exc_valid;
  logic [1:0]  exc_cause;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [4:0]  rd;
    logic        rw;
    logic [31:0] data;
    logic        exc;
    logic [1:0]  cause;
    logic        chkd;
  } wb_t;

  wb_t exp_q[$];

  lsu_stage #(.ADDR_W(32), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
    .ex_alu_result(ex_alu_result), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_data(wb_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .exc_valid(exc_valid), .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [4:0] rd, input logic rw, input logic [31:0] data,
                          input logic exc, input logic [1:0] cause, input logic chkd);
    wb_t e;
    e.rd = rd; e.rw = rw; e.data = data; e.exc = exc; e.cause = cause; e.chkd = chkd;
    exp_q.push_back(e);
  endtask

  task automatic expect_wb(input string tag);
    wb_t e;
    chk({tag, "_wb_valid"}, wb_valid, 1);
    chk({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_wb_rd"}, wb_rd, e.rd);
      chk({tag, "_wb_reg_write"}, wb_reg_write, e.rw);
      chk({tag, "_exc_valid"}, exc_valid, e.exc);
      if (e.exc)  chk({tag, "_exc_cause"}, exc_cause, e.cause);
      if (e.chkd) chk({tag, "_wb_data"}, wb_data, e.data);
    end
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_no_wb"}, wb_valid, 0);
    chk({tag, "_no_exc"}, exc_valid, 0);
  endtask

  task automatic accept(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] alu,
                        input logic [4:0] rd, input logic rw);
    chk("ex_ready_before_accept", ex_ready, 1);
    ex_valid = 1'b1; ex_mem_read = rd_en; ex_mem_write = wr_en; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wdata; ex_alu_result = alu; ex_rd = rd; ex_reg_write = rw;
    @(negedge clk);
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rdata, input logic [4:0] rd,
                         input logic [3:0] be, input logic [31:0] data);
    push_exp(rd, 1'b1, data, 1'b0, 2'd0, 1'b1);
    accept(1'b1, 1'b0, f3, addr, 32'h0, 32'h0, rd, 1'b1);
    chk({tag, "_bus_req"}, bus_req, 1);
    chk({tag, "_bus_we"}, bus_we, 0);
    chk({tag, "_bus_addr"}, bus_addr, addr & 32'hFFFF_FFFC);
    chk({tag, "_bus_be"}, bus_be, be);
    chk({tag, "_stall"}, ex_ready, 0);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    chk({tag, "_req_dropped"}, bus_req, 0);
    expect_idle({tag, "_resp_wait"});
    bus_rvalid = 1'b1; bus_rdata = rdata;
    @(negedge clk);
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    expect_wb(tag);
    chk({tag, "_ready_after"}, ex_ready, 1);
  endtask

  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [4:0] rd, input logic [3:0] be,
                          input logic [31:0] bwd, input int gnt_delay);
    push_exp(rd, 1'b0, 32'h0, 1'b0, 2'd0, 1'b0);
    accept(1'b0, 1'b1, f3, addr, wdata, 32'h0, rd, 1'b1);
    for (int i = 0; i <= gnt_delay; i++) begin
      chk({tag, "_bus_req"}, bus_req, 1);
      chk({tag, "_bus_we"}, bus_we, 1);
      chk({tag, "_bus_addr"}, bus_addr, addr & 32'hFFFF_FFFC);
      chk({tag, "_bus_be"}, bus_be, be);
      chk({tag, "_bus_wdata"}, bus_wdata, bwd);
      chk({tag, "_stall"}, ex_ready, 0);
      if (i == gnt_delay) bus_gnt = 1'b1;
      @(negedge clk);
    end
    bus_gnt = 1'b0;
    chk({tag, "_req_dropped"}, bus_req, 0);
    expect_wb(tag);
  endtask

  task automatic do_exc(input string tag, input logic rd_en, input logic wr_en,
                        input logic [2:0] f3, input logic [31:0] addr, input logic [1:0] cause);
    push_exp(5'd11, 1'b0, 32'h0, 1'b1, cause, 1'b0);
    accept(rd_en, wr_en, f3, addr, 32'h5555_AAAA, 32'h0, 5'd11, 1'b1);
    chk({tag, "_no_bus_req"}, bus_req, 0);
    expect_wb(tag);
  endtask

  task automatic do_alu(input string tag, input logic [31:0] alu, input logic [4:0] rd);
    push_exp(rd, 1'b1, alu, 1'b0, 2'd0, 1'b1);
    accept(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, alu, rd, 1'b1);
    chk({tag, "_no_bus_req"}, bus_req, 0);
    expect_wb(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = 3'b000;
    ex_addr = 32'h0; ex_wdata = 32'h0; ex_alu_result = 32'h0; ex_rd = 5'd0; ex_reg_write = 1'b0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(negedge clk);

    chk("rst_ex_ready", ex_ready, 1);
    chk("rst_bus_req", bus_req, 0);
    chk("rst_bus_we", bus_we, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_bus_be", bus_be, 0);
    chk("rst_bus_wdata", bus_wdata, 0);
    expect_idle("rst");
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_wb_reg_write", wb_reg_write, 0);
    chk("rst_exc_cause", exc_cause, 0);
    rst = 1'b0;
    @(negedge clk);

    do_alu("alu_add", 32'h0000_1234, 5'd5);
    @(negedge clk);
    expect_idle("alu_single_pulse");

    do_load("lb_103",  3'b000, 32'h0000_0103, 32'h80FF_FF7F, 5'd7, 4'b1000, 32'hFFFF_FF80);
    do_load("lbu_103", 3'b100, 32'h0000_0103, 32'h80FF_FF7F, 5'd8, 4'b1000, 32'h0000_0080);
    do_load("lh_302",  3'b001, 32'h0000_0302, 32'h8001_7FFF, 5'd9, 4'b1100, 32'hFFFF_8001);
    do_load("lhu_300", 3'b101, 32'h0000_0300, 32'h8001_7FFF, 5'd10, 4'b0011, 32'h0000_7FFF);
    do_load("lb_101",  3'b000, 32'h0000_0101, 32'h1234_5678, 5'd12, 4'b0010, 32'h0000_0056);
    do_load("lw_400",  3'b010, 32'h0000_0400, 32'hDEAD_BEEF, 5'd13, 4'b1111, 32'hDEAD_BEEF);

    do_store("sh_202", 3'b001, 32'h0000_0202, 32'h1234_ABCD, 5'd14, 4'b1100, 32'hABCD_ABCD, 3);
    do_alu("b2b_after_store", 32'h0000_CAFE, 5'd15);
    do_store("sb_005", 3'b000, 32'h0000_0005, 32'h0000_00A5, 5'd16, 4'b0010, 32'hA5A5_A5A5, 0);
    do_store("sw_008", 3'b010, 32'h0000_0008, 32'h1357_9BDF, 5'd17, 4'b1111, 32'h1357_9BDF, 1);

    do_exc("lw_006_misal",  1'b1, 1'b0, 3'b010, 32'h0000_0006, 2'd0);
    do_exc("sw_001_misal",  1'b0, 1'b1, 3'b010, 32'h0000_0001, 2'd1);
    do_exc("ld_f3_011",     1'b1, 1'b0, 3'b011, 32'h0000_0000, 2'd3);
    do_exc("rd_and_wr",     1'b1, 1'b1, 3'b010, 32'h0000_0000, 2'd3);
    do_exc("lh_101_misal",  1'b1, 1'b0, 3'b001, 32'h0000_0101, 2'd0);
    do_exc("lhu_001_misal", 1'b1, 1'b0, 3'b101, 32'h0000_0001, 2'd0);
    do_exc("sh_003_misal",  1'b0, 1'b1, 3'b001, 32'h0000_0003, 2'd1);
    do_exc("st_f3_100",     1'b0, 1'b1, 3'b100, 32'h0000_0000, 2'd3);
    @(negedge clk);
    expect_idle("exc_single_pulse");

    bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    @(negedge clk);
    expect_idle("stray_rvalid");

    accept(1'b1, 1'b0, 3'b010, 32'h0000_0010, 32'h0, 32'h0, 5'd3, 1'b1);
    chk("abandon_bus_req", bus_req, 1);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abandon_bus_req_low", bus_req, 0);
    chk("abandon_ex_ready", ex_ready, 1);
    chk("abandon_bus_addr", bus_addr, 0);
    chk("abandon_bus_be", bus_be, 0);
    chk("abandon_wb_data", wb_data, 0);
    chk("abandon_wb_rd", wb_rd, 0);
    expect_idle("abandon_rst");
    bus_rvalid = 1'b1; bus_rdata = 32'h7777_7777;
    @(negedge clk);
    bus_rvalid = 1'b0; bus_rdata = 32'h0;
    expect_idle("abandon_late_rvalid");
    chk("abandon_wb_data_after", wb_data, 0);
    @(negedge clk);
    expect_idle("abandon_late_rvalid2");

`ifdef LSU_TIMEOUT_EN
    begin
      int n;
      n = 0;
      push_exp(5'd20, 1'b0, 32'h0, 1'b1, 2'd2, 1'b0);
      accept(1'b1, 1'b0, 3'b010, 32'h0000_0040, 32'h0, 32'h0, 5'd20, 1'b1);
      for (int i = 0; i < 20; i++) begin
        if (bus_req) begin
          n++;
          @(negedge clk);
        end
      end
      chk("timeout_req_cycles", n, 8);
      chk("timeout_req_low", bus_req, 0);
      expect_wb("timeout");
      bus_rvalid = 1'b1; bus_rdata = 32'h1111_1111;
      @(negedge clk);
      bus_rvalid = 1'b0;
      expect_idle("timeout_late_rvalid");
      chk("timeout_ready", ex_ready, 1);
    end
`endif

    chk("sb_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
